data_memory_unit: RTL and testbench



---
 rtl/dmem_if.sv | 45 ++++
 rtl/data_memory_unit.sv | 167 ++++++++++++++++
 tb/tb_data_memory_unit.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_if.sv
// dmem_if: request/response bundle between the register-file stage and
// data_memory_unit.
//
// Handshake: a request transfers on a rising clk edge where req_valid and
// req_ready are both high; the requester holds req_valid and the request
// fields stable until that edge. The response is a single-cycle strobe
// (rsp_valid) with no back-pressure, so the consumer must take it when it
// appears.
//
// Signals:
//   req_valid/req_ready  request handshake
//   req_we               1 = store word, 0 = load word
//   req_addr             effective byte address
//   req_wdata            store data
//   req_rd               destination register tag
//   rsp_valid            one-cycle response strobe
//   rsp_lw               load-completion strobe (register file write enable)
//   rsp_data             load data (0 for stores and faults)
//   rsp_rd               echoed destination tag
//   rsp_err              access fault
//   busy                 transaction in flight
interface dmem_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [4:0]  req_rd;
    logic        rsp_valid;
    logic        rsp_lw;
    logic [31:0] rsp_data;
    logic [4:0]  rsp_rd;
    logic        rsp_err;
    logic        busy;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_rd,
        input  req_ready, rsp_valid, rsp_lw, rsp_data, rsp_rd, rsp_err, busy
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_rd,
        output req_ready, rsp_valid, rsp_lw, rsp_data, rsp_rd, rsp_err, busy
    );
endinterface

// File: rtl/data_memory_unit.sv
// data_memory_unit: data-memory stage behind the register file.
//
// Accepts one load/store word request at a time, spends ACCESS_LAT cycles
// in BUSY, performs the array access on the last BUSY edge and presents a
// registered one-cycle response in RESP. Loads return data plus rsp_lw,
// which drives the register file write port.
//
// Ports:
//   clk        clock, all state on rising edge
//   reset      asynchronous, active-high reset
//   bus        dmem_if.slave request/response bundle
//   dbg_state  current FSM state (IDLE=0, BUSY=1, RESP=2)
//
// Optional feature (macro DMEM_ERR_EN): when defined, a request whose byte
// address is misaligned or lies beyond DEPTH words faults: it still spends
// ACCESS_LAT cycles in BUSY, touches no memory, and responds with rsp_err=1,
// rsp_lw=0, rsp_data=0. When undefined, rsp_err is always 0 and the low two
// and upper address bits are ignored, so addresses wrap modulo DEPTH words.
module data_memory_unit #(
    parameter int DEPTH      = 256,
    parameter int ADDR_W     = 8,
    parameter int ACCESS_LAT = 2
) (
    input  logic       clk,
    input  logic       reset,
    dmem_if.slave      bus,
    output logic [1:0] dbg_state
);

    localparam int CNT_W = $clog2(ACCESS_LAT + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic               we_q, we_d;
    logic [31:0]        addr_q, addr_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [4:0]         rd_q, rd_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic               rsp_lw_q, rsp_lw_d;
    logic [31:0]        rsp_data_q, rsp_data_d;
    logic [4:0]         rsp_rd_q, rsp_rd_d;
    logic               rsp_err_q, rsp_err_d;

    // Word array; contents are deliberately not reset.
    logic [31:0]        mem [DEPTH];
    logic [ADDR_W-1:0]  idx;
    logic               mem_we;
    logic               fault;

    assign idx = addr_q[ADDR_W+1:2];

`ifdef DMEM_ERR_EN
    assign fault = (addr_q[1:0] != 2'b00) || (addr_q[31:ADDR_W+2] != '0);
`else
    // Ignored address bits; reduced into a sink so they do not look dangling.
    logic addr_unused;
    assign addr_unused = ^{addr_q[31:ADDR_W+2], addr_q[1:0]};
    assign fault       = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rd_d        = rd_q;
        cnt_d       = cnt_q;
        // Response registers default to 0 so they are high/non-zero only
        // for the single RESP cycle.
        rsp_valid_d = 1'b0;
        rsp_lw_d    = 1'b0;
        rsp_data_d  = 32'h0;
        rsp_rd_d    = 5'h0;
        rsp_err_d   = 1'b0;
        mem_we      = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    we_d    = bus.req_we;
                    addr_d  = bus.req_addr;
                    wdata_d = bus.req_wdata;
                    rd_d    = bus.req_rd;
                    cnt_d   = CNT_W'(ACCESS_LAT);
                    state_d = BUSY;
                end
            end
            BUSY: begin
                cnt_d = cnt_q - CNT_W'(1);
                // Last BUSY edge: do the access and load the response
                // registers so they appear together in RESP.
                if (cnt_q == CNT_W'(1)) begin
                    state_d     = RESP;
                    rsp_valid_d = 1'b1;
                    rsp_rd_d    = rd_q;
                    rsp_err_d   = fault;
                    if (!fault) begin
                        if (we_q) begin
                            mem_we = 1'b1;
                        end else begin
                            rsp_lw_d   = 1'b1;
                            rsp_data_d = mem[idx];
                        end
                    end
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            we_q        <= 1'b0;
            addr_q      <= 32'h0;
            wdata_q     <= 32'h0;
            rd_q        <= 5'h0;
            cnt_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_lw_q    <= 1'b0;
            rsp_data_q  <= 32'h0;
            rsp_rd_q    <= 5'h0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rd_q        <= rd_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_lw_q    <= rsp_lw_d;
            rsp_data_q  <= rsp_data_d;
            rsp_rd_q    <= rsp_rd_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // mem_we derives from state_q, so an asynchronous reset during BUSY
    // drops the pending store before it can land.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[idx] <= wdata_q;
        end
    end

    assign bus.req_ready = (state_q == IDLE);
    assign bus.busy      = (state_q != IDLE);
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_lw    = rsp_lw_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_rd    = rsp_rd_q;
    assign bus.rsp_err   = rsp_err_q;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_data_memory_unit.sv
module tb_data_memory_unit;

    localparam int DEPTH      = 256;
    localparam int ADDR_W     = 8;
    localparam int ACCESS_LAT = 2;

    logic       clk;
    logic       reset;
    logic [1:0] dbg_state;

    dmem_if bus_if ();

    data_memory_unit #(
        .DEPTH      (DEPTH),
        .ADDR_W     (ADDR_W),
        .ACCESS_LAT (ACCESS_LAT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus_if),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- scoreboard state ----------------
    int errors = 0;
    int checks = 0;

    // Expected response packed as {err, lw, rd[4:0], data[31:0]}.
    logic [38:0] exp_q[$];

    // Reference memory: word contents plus a flag for words written so far.
    logic [31:0] ref_mem   [DEPTH];
    bit          ref_known [DEPTH];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Behavioural model: one transaction in, expected response out.
    task automatic model_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [4:0] rd, output logic [38:0] exp, output bit known);
        int  w;
        bit  flt;
        w     = int'((addr >> 2) % DEPTH);
        flt   = 1'b0;
`ifdef DMEM_ERR_EN
        flt   = (addr % 4 != 0) || ((addr >> 2) >= DEPTH);
`endif
        known = 1'b1;
        if (flt) begin
            exp = {1'b1, 1'b0, rd, 32'h0};
        end else if (we) begin
            ref_mem[w]   = wdata;
            ref_known[w] = 1'b1;
            exp = {1'b0, 1'b0, rd, 32'h0};
        end else begin
            known = ref_known[w];
            exp   = {1'b0, 1'b1, rd, known ? ref_mem[w] : 32'h0};
        end
    endtask

    function automatic logic [38:0] rsp_vec();
        return {bus_if.rsp_err, bus_if.rsp_lw, bus_if.rsp_rd, bus_if.rsp_data};
    endfunction

    // ---------------- driver ----------------
    // Issues one request from IDLE and checks latency, ready/busy during the
    // access, the response contents and the return to idle.
    task automatic run_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [4:0] rd);
        logic [38:0] exp;
        bit          known;
        int          k;
        bit          seen;
        @(negedge clk);
        check_eq("ready_before_req", bus_if.req_ready, 1);
        bus_if.req_valid = 1'b1;
        bus_if.req_we    = we;
        bus_if.req_addr  = addr;
        bus_if.req_wdata = wdata;
        bus_if.req_rd    = rd;
        @(posedge clk);
        #1;
        bus_if.req_valid = 1'b0;
        model_txn(we, addr, wdata, rd, exp, known);
        k    = 0;
        seen = 1'b0;
        while (!seen && k < ACCESS_LAT + 4) begin
            @(negedge clk);
            k++;
            if (bus_if.rsp_valid) begin
                seen = 1'b1;
            end else begin
                check_eq("busy_during_access", {bus_if.busy, bus_if.req_ready}, 2'b10);
            end
        end
        check_eq("rsp_latency", k, ACCESS_LAT + 1);
        if (seen) begin
            check_eq("ready_in_resp", bus_if.req_ready, 0);
            if (known) check_eq("rsp_fields", rsp_vec(), exp);
            else       check_eq("rsp_ctrl", rsp_vec() >> 32, exp >> 32);
        end
        @(negedge clk);
        check_eq("rsp_cleared", {bus_if.rsp_valid, rsp_vec()}, 40'h0);
        check_eq("idle_after_rsp", {bus_if.busy, bus_if.req_ready}, 2'b01);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [38:0] e;
        logic [31:0] a;
        int          n_acc;
        int          n_rsp;
        bit          acc;
        logic [31:0] alt_data [6];

        for (int i = 0; i < DEPTH; i++) ref_known[i] = 1'b0;
        bus_if.req_valid = 1'b0;
        bus_if.req_we    = 1'b0;
        bus_if.req_addr  = 32'h0;
        bus_if.req_wdata = 32'h0;
        bus_if.req_rd    = 5'h0;
        reset = 1'b1;

        // Reset state
        @(negedge clk);
        check_eq("reset_ready_busy", {bus_if.req_ready, bus_if.busy}, 2'b10);
        check_eq("reset_rsp", {bus_if.rsp_valid, rsp_vec()}, 40'h0);
        check_eq("reset_state", dbg_state, 0);
        @(negedge clk);
        reset = 1'b0;

        // Store then load back with rd=5
        run_txn(1'b1, 32'h10, 32'hDEADBEEF, 5'd2);
        run_txn(1'b0, 32'h10, 32'h0, 5'd5);

        // Store 0x1234 to address 0
        run_txn(1'b1, 32'h0, 32'h00001234, 5'd0);

        // Out-of-range and misaligned loads: wrap or fault depending on build
        run_txn(1'b0, 32'h400, 32'h0, 5'd9);
        run_txn(1'b0, 32'h13, 32'h0, 5'd10);

        // Back-to-back loads with distinct tags
        run_txn(1'b0, 32'h10, 32'h0, 5'd1);
        run_txn(1'b0, 32'h0, 32'h0, 5'd31);

        // Reset during the BUSY phase of a store
        run_txn(1'b1, 32'h20, 32'h11111111, 5'd3);
        @(negedge clk);
        bus_if.req_valid = 1'b1;
        bus_if.req_we    = 1'b1;
        bus_if.req_addr  = 32'h20;
        bus_if.req_wdata = 32'hCAFE0000;
        bus_if.req_rd    = 5'd4;
        @(posedge clk);
        #1;
        bus_if.req_valid = 1'b0;
        @(negedge clk);
        check_eq("busy_before_reset", bus_if.busy, 1);
        reset = 1'b1;
        #1;
        check_eq("reset_mid_ready_busy", {bus_if.req_ready, bus_if.busy}, 2'b10);
        check_eq("reset_mid_rsp", {bus_if.rsp_valid, rsp_vec()}, 40'h0);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < ACCESS_LAT + 2; i++) begin
            @(negedge clk);
            check_eq("no_rsp_after_reset", bus_if.rsp_valid, 0);
        end
        run_txn(1'b0, 32'h20, 32'h0, 5'd6);

        // req_valid held high with alternating store/load; every request
        // must produce exactly one response, in order.
        for (int i = 0; i < 6; i++) alt_data[i] = $urandom;
        n_acc = 0;
        n_rsp = 0;
        @(negedge clk);
        bus_if.req_valid = 1'b1;
        bus_if.req_we    = 1'b1;
        bus_if.req_addr  = 32'h80;
        bus_if.req_wdata = alt_data[0];
        bus_if.req_rd    = 5'd0;
        for (int cyc = 0; cyc < 80 && n_rsp < 6; cyc++) begin
            if (cyc != 0) @(negedge clk);
            if (bus_if.rsp_valid) begin
                if (exp_q.size() == 0) begin
                    check_eq("alt_extra_rsp", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check_eq("alt_rsp", rsp_vec(), e);
                end
                n_rsp++;
            end
            acc = bus_if.req_valid && bus_if.req_ready;
            @(posedge clk);
            #1;
            if (acc) begin
                bit kn;
                model_txn(bus_if.req_we, bus_if.req_addr, bus_if.req_wdata, bus_if.req_rd, e, kn);
                exp_q.push_back(e);
                n_acc++;
                if (n_acc < 6) begin
                    bus_if.req_we    = ~bus_if.req_we;
                    bus_if.req_addr  = 32'h80 + 32'((n_acc / 2) * 4);
                    bus_if.req_wdata = alt_data[n_acc];
                    bus_if.req_rd    = 5'(n_acc + 1);
                end else begin
                    bus_if.req_valid = 1'b0;
                end
            end
        end
        check_eq("alt_accepted", n_acc, 6);
        check_eq("alt_responses", n_rsp, 6);
        check_eq("alt_queue_empty", exp_q.size(), 0);
        // Let the unit settle back to IDLE.
        for (int i = 0; i < ACCESS_LAT + 3 && bus_if.busy; i++) @(negedge clk);

        // Randomized traffic over a small window plus aliased/faulting addresses
        for (int t = 0; t < 24; t++) begin
            a = 32'($urandom_range(0, 15)) << 2;
            case ($urandom_range(0, 5))
                0: a = a | 32'($urandom_range(1, 3));
                1: a = a | (32'($urandom_range(1, 7)) << (ADDR_W + 2));
                default: ;
            endcase
            run_txn(1'($urandom_range(0, 1)), a, $urandom, 5'($urandom_range(0, 31)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
